vgpr_rd_port_arbiter: RTL and testbench

- Shares the single VGPR bank read port between two requesters: port0 (SIMD/ALU operand fetch) and port1 (LSU store-data/address fetch).
- Uses a request/grant handshake with round-robin arbitration on conflict.
- Drives a registered read enable and address into the VGPR bank.
- Returns bank read data to the winning requester with a per-port data-valid strobe, aligned to a configurable bank read latency.

---
 rtl/vgpr_rd_port_arbiter_pkg.sv | 14 +
 rtl/vgpr_rd_tag_pipe.sv | 30 +++
 rtl/vgpr_rd_port_arbiter.sv | 109 ++++++++++
 tb/tb_vgpr_rd_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vgpr_rd_port_arbiter_pkg.sv
// Shared VGPR read-port definitions: default widths, port ids and latency bound.
package vgpr_rd_port_arbiter_pkg;
   localparam int VGPR_ADDR_W         = 10;
   localparam int VGPR_DATA_W         = 2048;
   localparam int VGPR_RD_MAX_LATENCY = 4;

   localparam logic VGPR_RD_PORT0 = 1'b0;
   localparam logic VGPR_RD_PORT1 = 1'b1;

   typedef struct packed {
      logic vld;
      logic port;
   } rd_tag_t;
endpackage

// File: rtl/vgpr_rd_tag_pipe.sv
// Return-tag delay line: {valid, port_id} shifted DEPTH cycles behind the bank read enable.
// Latency: DEPTH cycles. No backpressure; reset flushes every stage.
module vgpr_rd_tag_pipe
   import vgpr_rd_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tag_vld,
   input  logic tag_port,
   output logic ret_vld,
   output logic ret_port
);

   rd_tag_t stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {tag_vld, tag_port};
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign ret_vld  = stage[DEPTH-1].vld;
   assign ret_port = stage[DEPTH-1].port;

endmodule

// File: rtl/vgpr_rd_port_arbiter.sv
// Round-robin arbiter sharing one VGPR bank read port between ALU (port0) and LSU (port1); VGPR_ARB_PERF_CNT_EN adds conflict/stall counters.
// Latency: grant to data_vld = 1 + RD_LATENCY cycles, one read per cycle.
// Backpressure: bank_stall blocks new grants only; issued reads always complete.
module vgpr_rd_port_arbiter
   import vgpr_rd_port_arbiter_pkg::*;
#(
   parameter int DATAWIDTH  = VGPR_DATA_W,
   parameter int ADDRWIDTH  = VGPR_ADDR_W,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 port0_rd_req,
   input  logic [ADDRWIDTH-1:0] port0_rd_addr,
   output logic                 port0_rd_gnt,
   output logic                 port0_rd_data_vld,
   input  logic                 port1_rd_req,
   input  logic [ADDRWIDTH-1:0] port1_rd_addr,
   output logic                 port1_rd_gnt,
   output logic                 port1_rd_data_vld,
   output logic [DATAWIDTH-1:0] port_rd_data,
   input  logic                 bank_stall,
   output logic                 rd_en,
   output logic [ADDRWIDTH-1:0] rd_addr,
   input  logic [DATAWIDTH-1:0] rd_data
`ifdef VGPR_ARB_PERF_CNT_EN
   ,
   output logic [15:0]          conflict_cnt,
   output logic [15:0]          stall_cnt
`endif
);

   if (RD_LATENCY < 1 || RD_LATENCY > VGPR_RD_MAX_LATENCY) begin : g_bad_latency
      $error("vgpr_rd_port_arbiter: RD_LATENCY out of range 1..4");
   end

   logic both_req;
   logic last_winner;
   logic issue_port;
   logic ret_vld;
   logic ret_port;

   assign both_req = port0_rd_req & port1_rd_req;

   // On conflict the port that did not win last time goes next.
   always_comb begin
      port0_rd_gnt = 1'b0;
      port1_rd_gnt = 1'b0;
      if (!bank_stall) begin
         if (both_req) begin
            port0_rd_gnt = (last_winner == VGPR_RD_PORT1);
            port1_rd_gnt = (last_winner == VGPR_RD_PORT0);
         end else begin
            port0_rd_gnt = port0_rd_req;
            port1_rd_gnt = port1_rd_req;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         issue_port  <= VGPR_RD_PORT0;
         last_winner <= VGPR_RD_PORT1;
      end else begin
         rd_en <= port0_rd_gnt | port1_rd_gnt;
         if (port0_rd_gnt) begin
            rd_addr     <= port0_rd_addr;
            issue_port  <= VGPR_RD_PORT0;
            last_winner <= VGPR_RD_PORT0;
         end else if (port1_rd_gnt) begin
            rd_addr     <= port1_rd_addr;
            issue_port  <= VGPR_RD_PORT1;
            last_winner <= VGPR_RD_PORT1;
         end
      end
   end

   vgpr_rd_tag_pipe #(
      .DEPTH (RD_LATENCY)
   ) u_tag_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .tag_vld  (rd_en),
      .tag_port (issue_port),
      .ret_vld  (ret_vld),
      .ret_port (ret_port)
   );

   assign port0_rd_data_vld = ret_vld & (ret_port == VGPR_RD_PORT0);
   assign port1_rd_data_vld = ret_vld & (ret_port == VGPR_RD_PORT1);
   assign port_rd_data      = rd_data;

`ifdef VGPR_ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (both_req && !bank_stall && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
         if ((port0_rd_req || port1_rd_req) && bank_stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vgpr_rd_port_arbiter.sv
// Bench for vgpr_rd_port_arbiter: RD_LATENCY=1 and RD_LATENCY=4 instances on shared stimulus.
module tb_vgpr_rd_port_arbiter;
   localparam int DW = 64;
   localparam int AW = 10;

   logic          clk;
   logic          rst_n;
   logic          req0, req1, stall;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] rd_data;

   logic          a_gnt0, a_gnt1, a_v0, a_v1, a_en;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_data;
   logic          b_gnt0, b_gnt1, b_v0, b_v1, b_en;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_data;
`ifdef VGPR_ARB_PERF_CNT_EN
   logic [15:0]   a_conf, a_stl, b_conf, b_stl;
`endif

   vgpr_rd_port_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RD_LATENCY(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .port0_rd_req(req0), .port0_rd_addr(addr0), .port0_rd_gnt(a_gnt0), .port0_rd_data_vld(a_v0),
      .port1_rd_req(req1), .port1_rd_addr(addr1), .port1_rd_gnt(a_gnt1), .port1_rd_data_vld(a_v1),
      .port_rd_data(a_data), .bank_stall(stall), .rd_en(a_en), .rd_addr(a_addr), .rd_data(rd_data)
`ifdef VGPR_ARB_PERF_CNT_EN
      , .conflict_cnt(a_conf), .stall_cnt(a_stl)
`endif
   );

   vgpr_rd_port_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .RD_LATENCY(4)) dut_l4 (
      .clk(clk), .rst_n(rst_n),
      .port0_rd_req(req0), .port0_rd_addr(addr0), .port0_rd_gnt(b_gnt0), .port0_rd_data_vld(b_v0),
      .port1_rd_req(req1), .port1_rd_addr(addr1), .port1_rd_gnt(b_gnt1), .port1_rd_data_vld(b_v1),
      .port_rd_data(b_data), .bank_stall(stall), .rd_en(b_en), .rd_addr(b_addr), .rd_data(rd_data)
`ifdef VGPR_ARB_PERF_CNT_EN
      , .conflict_cnt(b_conf), .stall_cnt(b_stl)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks, n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: last winner, expected bank issue, and per-cycle return schedule
   // (0 = nothing returns, 1 = port0 data, 2 = port1 data) indexed by cycle modulo 8.
   int            cyc;
   int            m_lw;
   bit            m_en;
   logic [AW-1:0] m_addr;
   int            sched1 [8];
   int            sched4 [8];
   int            m_conf, m_stall;
   int            obs_g;      // observed grant this cycle: 0, 1 or -1
   int            exp_g;      // model grant this cycle

   task automatic model_reset();
      m_lw = 1; m_en = 0; m_addr = '0; m_conf = 0; m_stall = 0; exp_g = -1;
      for (int i = 0; i < 8; i++) begin sched1[i] = 0; sched4[i] = 0; end
   endtask

   // Called shortly after a rising edge with inputs already set; returns just after the next one.
   task automatic step();
      int winner;
      rd_data = {$urandom, $urandom};
      @(negedge clk);
      winner = -1;
      if (!stall) begin
         if (req0 && req1) winner = 1 - m_lw;
         else if (req0)    winner = 0;
         else if (req1)    winner = 1;
      end
      obs_g = a_gnt0 ? 0 : (a_gnt1 ? 1 : -1);
      chk("gnt0_l1", a_gnt0, winner == 0);
      chk("gnt1_l1", a_gnt1, winner == 1);
      chk("gnt0_l4", b_gnt0, winner == 0);
      chk("gnt1_l4", b_gnt1, winner == 1);
      chk("rd_en_l1", a_en, m_en);
      chk("rd_addr_l1", a_addr, m_addr);
      chk("rd_en_l4", b_en, m_en);
      chk("rd_addr_l4", b_addr, m_addr);
      chk("vld0_l1", a_v0, sched1[cyc % 8] == 1);
      chk("vld1_l1", a_v1, sched1[cyc % 8] == 2);
      chk("vld0_l4", b_v0, sched4[cyc % 8] == 1);
      chk("vld1_l4", b_v1, sched4[cyc % 8] == 2);
      chk("data_l1", a_data, rd_data);
      chk("data_l4", b_data, rd_data);
`ifdef VGPR_ARB_PERF_CNT_EN
      chk("conflict_cnt", a_conf, m_conf);
      chk("stall_cnt", a_stl, m_stall);
      chk("conflict_cnt_l4", b_conf, m_conf);
      chk("stall_cnt_l4", b_stl, m_stall);
`endif
      sched1[cyc % 8] = 0;
      sched4[cyc % 8] = 0;
      exp_g = winner;
      m_en  = (winner >= 0);
      if (winner >= 0) begin
         m_addr = (winner == 0) ? addr0 : addr1;
         m_lw   = winner;
         sched1[(cyc + 2) % 8] = winner + 1;
         sched4[(cyc + 5) % 8] = winner + 1;
      end
      if (req0 && req1 && !stall && m_conf < 65535) m_conf++;
      if ((req0 || req1) && stall && m_stall < 65535) m_stall++;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      req0 = 0; req1 = 0; stall = 0;
      rst_n = 0;
      #1;
      chk("rst_rd_en", {a_en, b_en}, 2'b00);
      chk("rst_rd_addr", {a_addr, b_addr}, '0);
      chk("rst_vld", {a_v0, a_v1, b_v0, b_v1}, 4'b0000);
      chk("rst_gnt", {a_gnt0, a_gnt1, b_gnt0, b_gnt1}, 4'b0000);
      model_reset();
      #1;
      rst_n = 1;
   endtask

   task automatic rand_inputs();
      // A pending, ungranted request must be held with a stable address.
      if (!(req0 && exp_g != 0)) begin
         req0  = ($urandom % 10) < 6;
         addr0 = AW'($urandom);
      end
      if (!(req1 && exp_g != 1)) begin
         req1  = ($urandom % 10) < 6;
         addr1 = AW'($urandom);
      end
      stall = ($urandom % 5) == 0;
   endtask

   int exp_seq [4];

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; obs_g = -1;
      rst_n = 0; req0 = 0; req1 = 0; stall = 0;
      addr0 = '0; addr1 = '0; rd_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      // Idle after reset
      repeat (10) step();

      // Single port0 read, then single port1 read
      req0 = 1; addr0 = 10'h05;
      step();
      chk("single_gnt0", obs_g, 0);
      req0 = 0;
      repeat (6) step();
      req1 = 1; addr1 = 10'h3A;
      step();
      chk("single_gnt1", obs_g, 1);
      req1 = 0;
      repeat (6) step();

      // Conflict: both held four cycles, last winner is port1
      exp_seq = '{0, 1, 0, 1};
      req0 = 1; addr0 = 10'h10; req1 = 1; addr1 = 10'h20;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("conflict_order", obs_g, exp_seq[i]);
      end

      // Stall straight after the conflict: in-flight reads still return
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_no_gnt", obs_g, -1);
      end
      stall = 0;
      step();
      chk("post_stall_gnt", obs_g, 0);
      req0 = 0; req1 = 0;
      repeat (6) step();

      // Mid-flight reset kills the RD_LATENCY=4 return
      req0 = 1; addr0 = 10'h33;
      step();
      step();
      pulse_reset();
      repeat (8) step();

`ifdef VGPR_ARB_PERF_CNT_EN
      pulse_reset();
      req0 = 1; req1 = 1;
      repeat (5) step();
      stall = 1;
      repeat (2) step();
      chk("perf_conflict5", a_conf, 16'd5);
      chk("perf_stall2", a_stl, 16'd2);
      stall = 0;
      repeat (70000) step();
      chk("perf_conflict_sat", a_conf, 16'hFFFF);
      req0 = 0; req1 = 0;
      repeat (6) step();
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom % 250 == 0) pulse_reset();
         else rand_inputs();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
